// File: rtl/cavlc_pkg.sv
// Shared constants for the CAVLC bit-window alignment stage.
package cavlc_pkg;

  localparam int WORD_W    = 32;
  localparam int WIN_W     = 16;
  localparam int BUF_W     = 64;
  localparam int MAX_SHIFT = 16;
  localparam int LEVEL_W   = 7;
  localparam int AMT_W     = 6;

endpackage

// File: rtl/cavlc_left_shifter.sv
// Combinational 64-bit left barrel shifter, amount 0..63, zero fill from the right.
module cavlc_left_shifter
  import cavlc_pkg::*;
(
  input  logic [BUF_W-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  output logic [BUF_W-1:0] o_data
);

  assign o_data = i_data << i_amt;

endmodule

// File: rtl/cavlc_bit_window.sv
// Bitstream alignment buffer: 64-bit left-aligned store, 16-bit lookahead window.
// Optional build macro CAVLC_BYTE_ALIGN_EN adds AlignEn and byte-alignment tracking.
module cavlc_bit_window #(
  parameter int WORD_W = 32,
  parameter int WIN_W  = 16,
  parameter int BUF_W  = 64
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [WORD_W-1:0]   InData,
  input  logic                InValid,
  output logic                InReady,
  output logic [WIN_W-1:0]    Window,
  output logic                WindowValid,
  input  logic                ShiftEn,
  input  logic [4:0]          ShiftAmt,
  output logic [6:0]          Level,
`ifdef CAVLC_BYTE_ALIGN_EN
  input  logic                AlignEn,
`endif
  output logic                ShiftErr
);
  import cavlc_pkg::*;

  logic [BUF_W-1:0]   r_buf;
  logic [LEVEL_W-1:0] r_count;
  logic               r_shift_err;

  logic               w_amt_ok;
  logic               w_shift;
  logic               w_load;
  logic               w_err;
  logic [4:0]         w_s;
  logic [LEVEL_W-1:0] w_rem;
  logic [AMT_W-1:0]   w_load_amt;
  logic [BUF_W-1:0]   w_consumed;
  logic [BUF_W-1:0]   w_placed;

  assign Window      = r_buf[BUF_W-1 -: WIN_W];
  assign WindowValid = (r_count >= LEVEL_W'(WIN_W));
  assign InReady     = (r_count <= LEVEL_W'(WORD_W));
  assign Level       = r_count;
  assign ShiftErr    = r_shift_err;

  assign w_amt_ok = (ShiftAmt != 5'd0) && (ShiftAmt <= 5'(MAX_SHIFT));
  assign w_shift  = ShiftEn & WindowValid & w_amt_ok;
  assign w_load   = InValid & InReady;

`ifdef CAVLC_BYTE_ALIGN_EN
  logic [2:0] r_bitpos;
  logic [2:0] w_align_amt;
  logic       w_align;

  // Bits still needed to reach the next byte boundary: (8 - BitPos) mod 8.
  assign w_align_amt = 3'd0 - r_bitpos;
  assign w_align     = AlignEn & ~ShiftEn & (r_count >= {4'd0, w_align_amt});
  assign w_s         = w_shift ? ShiftAmt : (w_align ? {2'b00, w_align_amt} : 5'd0);
  assign w_err       = (ShiftEn & ~w_shift) | (ShiftEn & AlignEn);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bitpos <= 3'd0;
    end else begin
      r_bitpos <= r_bitpos + w_s[2:0];
    end
  end
`else
  assign w_s   = w_shift ? ShiftAmt : 5'd0;
  assign w_err = ShiftEn & ~w_shift;
`endif

  // A load only happens with Count <= 32, so the remainder fits in 6 bits there.
  assign w_rem      = r_count - {2'b00, w_s};
  assign w_load_amt = 6'd32 - w_rem[AMT_W-1:0];

  cavlc_left_shifter u_consume_shift (
    .i_data (r_buf),
    .i_amt  ({1'b0, w_s}),
    .o_data (w_consumed)
  );

  cavlc_left_shifter u_load_shift (
    .i_data ({{(BUF_W-WORD_W){1'b0}}, InData}),
    .i_amt  (w_load_amt),
    .o_data (w_placed)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_buf       <= '0;
      r_count     <= '0;
      r_shift_err <= 1'b0;
    end else begin
      r_buf       <= w_consumed | (w_load ? w_placed : '0);
      r_count     <= w_rem + (w_load ? LEVEL_W'(WORD_W) : '0);
      r_shift_err <= r_shift_err | w_err;
    end
  end

endmodule
